// File: rtl/fan_supervisor_if.sv
// -----------------------------------------------------------------------------
// fan_supervisor_if
// Signal bundle between the fan supervisor and its surroundings.
//   speed_req  [11:0]  requested duty from the temperature controller
//   rpm        [15:0]  measured fan speed from the tach counter
//   temp       [11:0]  die temperature, 0.1 C units, unsigned
//   clr_fault          single-cycle pulse that releases FAULT
//   speed_out  [11:0]  supervised duty towards the PWM generator
//   fault              high while the supervisor sits in FAULT
//   overtemp           over-temperature override active
//   state      [2:0]   FSM state: OFF=0 KICK=1 RUN=2 RETRY=3 FAULT=4
// master: the side that drives requests/measurements and reads status.
// slave : the supervisor itself.
// -----------------------------------------------------------------------------
interface fan_supervisor_if;
  logic [11:0] speed_req;
  logic [15:0] rpm;
  logic [11:0] temp;
  logic        clr_fault;
  logic [11:0] speed_out;
  logic        fault;
  logic        overtemp;
  logic [2:0]  state;

  modport master (
    output speed_req, rpm, temp, clr_fault,
    input  speed_out, fault, overtemp, state
  );

  modport slave (
    input  speed_req, rpm, temp, clr_fault,
    output speed_out, fault, overtemp, state
  );
endinterface

// File: rtl/fan_supervisor.sv
// -----------------------------------------------------------------------------
// fan_supervisor
// Supervises a cooling fan: spins it up with a full-duty kick, passes the
// requested duty through while it runs, detects stalls from the tach rpm,
// retries a limited number of times and then latches FAULT. An
// over-temperature override with hysteresis forces full duty in every state.
// Ports:
//   clk   system clock, all state on the rising edge
//   rstn  asynchronous active-low reset
//   bus   fan_supervisor_if.slave (see the interface for signal meanings)
// -----------------------------------------------------------------------------
module fan_supervisor #(
  parameter int CLK_HZ    = 50000000,
  parameter int KICK_MS   = 500,
  parameter int STALL_MS  = 2000,
  parameter int MIN_RPM   = 300,
  parameter int MAX_RETRY = 3,
  parameter int TEMP_CRIT = 850,
  parameter int TEMP_HYST = 50
) (
  input  logic            clk,
  input  logic            rstn,
  fan_supervisor_if.slave bus
);

  typedef enum logic [2:0] {
    ST_OFF   = 3'd0,
    ST_KICK  = 3'd1,
    ST_RUN   = 3'd2,
    ST_RETRY = 3'd3,
    ST_FAULT = 3'd4
  } state_e;

  localparam int TICK_DIV = (CLK_HZ / 1000 > 0) ? CLK_HZ / 1000 : 1;
  localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  // Timers only need to count up to their limit; one extra state of headroom
  // keeps the comparison against the limit free of wrap.
  localparam int KW       = $clog2(KICK_MS + 1);
  localparam int SW       = $clog2(STALL_MS + 1);
  localparam int RW       = ($clog2(MAX_RETRY + 1) > 3) ? $clog2(MAX_RETRY + 1) : 3;

  localparam logic [TW-1:0] TICK_LAST  = TW'(TICK_DIV - 1);
  localparam logic [KW-1:0] KICK_LAST  = KW'(KICK_MS - 1);
  localparam logic [KW-1:0] KICK_MAX   = KW'(KICK_MS);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_MS - 1);
  localparam logic [SW-1:0] STALL_MAX  = SW'(STALL_MS);
  localparam logic [RW-1:0] RETRY_LIM  = RW'(MAX_RETRY);
  localparam logic [15:0]   MIN_RPM_W  = 16'(MIN_RPM);
  localparam logic [11:0]   TEMP_SET   = 12'(TEMP_CRIT);
  localparam logic [11:0]   TEMP_REL   = 12'(TEMP_CRIT - TEMP_HYST);
  localparam logic [11:0]   DUTY_FULL  = 12'hFFF;

  // ---------------------------------------------------------------------------
  // 1 ms tick
  // ---------------------------------------------------------------------------
  logic [TW-1:0] tick_q;
  logic          ms_tick;

  assign ms_tick = (tick_q == TICK_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tick_q <= '0;
    end else if (ms_tick) begin
      tick_q <= '0;
    end else begin
      tick_q <= tick_q + TW'(1);
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  state_e        state_q,     state_d;
  logic [KW-1:0] kick_q,      kick_d;
  logic [SW-1:0] stall_q,     stall_d;
  logic [RW-1:0] retry_q,     retry_d;
  logic          ot_q,        ot_d;
  logic [11:0]   speed_out_q, speed_out_d;
  logic          fault_q,     fault_d;

  always_comb begin
    // Over-temperature with hysteresis: set at/above CRIT, release strictly
    // below CRIT-HYST, hold in between.
    ot_d = ot_q;
    if (bus.temp >= TEMP_SET) begin
      ot_d = 1'b1;
    end else if (bus.temp < TEMP_REL) begin
      ot_d = 1'b0;
    end

    state_d = state_q;
    kick_d  = kick_q;
    stall_d = stall_q;
    retry_d = retry_q;

    unique case (state_q)
      ST_OFF: begin
        if (bus.speed_req != 12'd0 || ot_q) begin
          state_d = ST_KICK;
          kick_d  = '0;
        end
      end

      ST_KICK: begin
        // Duration is counted in ticks only; speed_req is ignored here and
        // picked up when RUN is entered.
        if (ms_tick) begin
          if (kick_q >= KICK_LAST) begin
            state_d = ST_RUN;
            stall_d = '0;
          end else if (kick_q != KICK_MAX) begin
            kick_d = kick_q + KW'(1);
          end
        end
      end

      ST_RUN: begin
        if (bus.speed_req == 12'd0 && !ot_q) begin
          state_d = ST_OFF;
          retry_d = '0;
          stall_d = '0;
        end else if (bus.rpm >= MIN_RPM_W) begin
          // A healthy reading forgives both the running stall time and
          // earlier stall attempts.
          stall_d = '0;
          retry_d = '0;
        end else if (ms_tick) begin
          if (stall_q >= STALL_LAST) begin
            state_d = ST_RETRY;
            stall_d = '0;
            if (retry_q != '1) begin
              retry_d = retry_q + RW'(1);
            end
          end else if (stall_q != STALL_MAX) begin
            stall_d = stall_q + SW'(1);
          end
        end
      end

      ST_RETRY: begin
        kick_d  = '0;
        state_d = (retry_q >= RETRY_LIM) ? ST_FAULT : ST_KICK;
      end

      ST_FAULT: begin
        if (bus.clr_fault) begin
          state_d = ST_OFF;
          retry_d = '0;
          kick_d  = '0;
          stall_d = '0;
        end
      end

      default: begin
        state_d = ST_OFF;
        kick_d  = '0;
        stall_d = '0;
        retry_d = '0;
      end
    endcase

    // Outputs follow the state being entered so they line up with state_q.
    unique case (state_d)
      ST_OFF:  speed_out_d = 12'd0;
      ST_RUN:  speed_out_d = bus.speed_req;
      default: speed_out_d = DUTY_FULL;
    endcase
    if (ot_d) begin
      speed_out_d = DUTY_FULL;
    end
    fault_d = (state_d == ST_FAULT);
  end

  // ---------------------------------------------------------------------------
  // FSM state, timers and registered outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= ST_OFF;
      kick_q      <= '0;
      stall_q     <= '0;
      retry_q     <= '0;
      ot_q        <= 1'b0;
      speed_out_q <= 12'd0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      kick_q      <= kick_d;
      stall_q     <= stall_d;
      retry_q     <= retry_d;
      ot_q        <= ot_d;
      speed_out_q <= speed_out_d;
      fault_q     <= fault_d;
    end
  end

  assign bus.speed_out = speed_out_q;
  assign bus.fault     = fault_q;
  assign bus.overtemp  = ot_q;
  assign bus.state     = state_q;

endmodule
